// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/owner encodings and address validity check for the memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP, ST_ERR} state_t;

    typedef enum logic [1:0] {OWN_I, OWN_D, OWN_LD} owner_t;

    // A byte address is unusable when it is not word aligned or points past the memory
    function automatic logic addr_bad(input logic [31:0] a, input int unsigned aw);
        return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin picker between instruction and data requests
module mem_arb_rr (
    input  logic req_i,
    input  logic req_d,
    input  logic last,
    output logic gnt_i,
    output logic gnt_d
);

    // last=1 means D won most recently, so I takes a tie; otherwise D takes it
    always_comb begin
        gnt_i = req_i & (~req_d | last);
        gnt_d = req_d & ~gnt_i;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch, data and loader ports onto one synchronous single-port RAM
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int MEM_WIDTH = 32,
    parameter  int MEM_SIZE  = 256,
    localparam int ADDR_W    = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    output logic                 i_ack,
    output logic                 i_err,
    output logic [MEM_WIDTH-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [31:0]          d_addr,
    input  logic [MEM_WIDTH-1:0] d_wdata,
    output logic                 d_ack,
    output logic                 d_err,
    output logic [MEM_WIDTH-1:0] d_rdata,
    input  logic                 ld_req,
    input  logic [31:0]          ld_addr,
    input  logic [MEM_WIDTH-1:0] ld_wdata,
    output logic                 ld_ack,
    output logic                 ld_err,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [MEM_WIDTH-1:0] mem_wdata,
    input  logic [MEM_WIDTH-1:0] mem_rdata,
    output logic                 core_stall
);

    state_t               state;
    owner_t               owner;
    owner_t               pick;
    logic                 last;
    logic                 req_ld;
    logic                 req_i;
    logic                 req_d;
    logic                 gnt_i;
    logic                 gnt_d;
    logic                 go;
    logic                 bad;
    logic                 sel_we;
    logic [31:0]          sel_addr;
    logic [MEM_WIDTH-1:0] sel_wdata;

    mem_arb_rr u_rr (
        .req_i (req_i),
        .req_d (req_d),
        .last  (last),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    // Candidate requests (the port just being answered is masked) and the winner's latched fields
    always_comb begin
        req_ld    = ld_req & ~(state == ST_RESP && owner == OWN_LD);
        req_i     = i_req & ~(state == ST_RESP && owner == OWN_I);
        req_d     = d_req & ~(state == ST_RESP && owner == OWN_D);
        go        = req_ld | gnt_i | gnt_d;
        pick      = req_ld ? OWN_LD : gnt_i ? OWN_I : OWN_D;
        sel_addr  = req_ld ? ld_addr : gnt_i ? i_addr : d_addr;
        sel_we    = req_ld ? 1'b1 : gnt_i ? 1'b0 : d_we;
        sel_wdata = req_ld ? ld_wdata : gnt_i ? '0 : d_wdata;
        bad       = addr_bad(sel_addr, ADDR_W);
    end

    // Control FSM: grant, drive the RAM for one cycle, then strobe the owner's ack
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_I;
            last      <= 1'b1;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            ld_ack    <= 1'b0;
            ld_err    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            i_ack  <= 1'b0;
            i_err  <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            ld_ack <= 1'b0;
            ld_err <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (go) begin
                        owner <= pick;
                        if (pick != OWN_LD)
                            last <= (pick == OWN_D);
                        if (bad) begin
                            state  <= ST_ERR;
                            i_ack  <= (pick == OWN_I);
                            i_err  <= (pick == OWN_I);
                            d_ack  <= (pick == OWN_D);
                            d_err  <= (pick == OWN_D);
                            ld_ack <= (pick == OWN_LD);
                            ld_err <= (pick == OWN_LD);
                        end else begin
                            state     <= ST_ACCESS;
                            mem_en    <= 1'b1;
                            mem_we    <= sel_we;
                            mem_addr  <= sel_addr[ADDR_W+1:2];
                            mem_wdata <= sel_wdata;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state  <= ST_RESP;
                    i_ack  <= (owner == OWN_I);
                    d_ack  <= (owner == OWN_D);
                    ld_ack <= (owner == OWN_LD);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read data is only forwarded during a successful acknowledge
    always_comb begin
        i_rdata    = (i_ack && !i_err) ? mem_rdata : '0;
        d_rdata    = (d_ack && !d_err) ? mem_rdata : '0;
        core_stall = (i_req & ~i_ack) | (d_req & ~d_ack);
    end

endmodule
